// File: rtl/axilregs_pkg.sv
// rtl/axilregs_pkg.sv - shared register offsets, types and helpers for the AXI4-Lite irq controller
package axilregs_pkg;

   localparam logic [31:0] IRQ_CTRL_OFF = 32'h00;
   localparam logic [31:0] IRQ_IER_OFF  = 32'h04;
   localparam logic [31:0] IRQ_RAW_OFF  = 32'h08;
   localparam logic [31:0] IRQ_ISR_OFF  = 32'h0C;
   localparam logic [31:0] IRQ_ICR_OFF  = 32'h10;
   localparam logic [31:0] IRQ_ISET_OFF = 32'h14;
   localparam logic [31:0] IRQ_MIS_OFF  = 32'h18;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [30:0] reserved;
      logic        gie;
   } ctrl_irq_reg_t;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_VALID} r_state_t;

   // Byte-lane bits [1:0] are ignored; everything past MIS is unmapped.
   function automatic logic irq_addr_mapped(input logic [31:0] addr);
      return (addr & ~32'h3) <= IRQ_MIS_OFF;
   endfunction

   function automatic logic [1:0] irq_resp(input logic [31:0] addr);
      return irq_addr_mapped(addr) ? RESP_OKAY : RESP_SLVERR;
   endfunction

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/axilregs_irq_ctrl_if.sv
// rtl/axilregs_irq_ctrl_if.sv - AXI4-Lite bus bundle between a master and the irq controller
interface axilregs_irq_ctrl_if #(parameter int ADDR_W = 5) ();
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_slave_if.sv
// rtl/axil_slave_if.sv - AXI4-Lite handshake FSMs, one outstanding write and one outstanding read
module axil_slave_if
   import axilregs_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   axilregs_irq_ctrl_if.slave s,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [3:0]        wr_strb,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       rd_data
);

   w_state_t          w_state_q;
   r_state_t          r_state_q;
   logic              awready_q, wready_q, bvalid_q, wr_en_q;
   logic [1:0]        bresp_q, rresp_q;
   logic [ADDR_W-1:0] awaddr_q;
   logic [31:0]       wdata_q, rdata_q;
   logic [3:0]        wstrb_q;
   logic              arready_q, rvalid_q;
   logic              aw_hs, w_hs, ar_hs;

   assign aw_hs = s.awvalid & awready_q;
   assign w_hs  = s.wvalid & wready_q;
   assign ar_hs = s.arvalid & arready_q;

   assign s.awready = awready_q;
   assign s.wready  = wready_q;
   assign s.bvalid  = bvalid_q;
   assign s.bresp   = bresp_q;
   assign s.arready = arready_q;
   assign s.rvalid  = rvalid_q;
   assign s.rdata   = rdata_q;
   assign s.rresp   = rresp_q;

   assign wr_en   = wr_en_q;
   assign wr_addr = awaddr_q;
   assign wr_data = wdata_q;
   assign wr_strb = wstrb_q;
   assign rd_en   = ar_hs;
   assign rd_addr = s.araddr;

   // wr_en pulses the cycle after both beats are held, so registers change one edge after bvalid rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         wr_en_q   <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         wr_en_q <= 1'b0;
         case (w_state_q)
            W_IDLE: begin
               if (aw_hs) awaddr_q <= s.awaddr;
               if (w_hs) begin
                  wdata_q <= s.wdata;
                  wstrb_q <= s.wstrb;
               end
               if (aw_hs && w_hs) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  wr_en_q   <= irq_addr_mapped(32'(s.awaddr));
                  bresp_q   <= irq_resp(32'(s.awaddr));
                  bvalid_q  <= 1'b1;
                  w_state_q <= W_RESP;
               end else if (aw_hs) begin
                  awready_q <= 1'b0;
                  w_state_q <= W_HAVE_AW;
               end else if (w_hs) begin
                  wready_q  <= 1'b0;
                  w_state_q <= W_HAVE_W;
               end else begin
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            W_HAVE_AW: if (w_hs) begin
               wdata_q   <= s.wdata;
               wstrb_q   <= s.wstrb;
               wready_q  <= 1'b0;
               wr_en_q   <= irq_addr_mapped(32'(awaddr_q));
               bresp_q   <= irq_resp(32'(awaddr_q));
               bvalid_q  <= 1'b1;
               w_state_q <= W_RESP;
            end
            W_HAVE_W: if (aw_hs) begin
               awaddr_q  <= s.awaddr;
               awready_q <= 1'b0;
               wr_en_q   <= irq_addr_mapped(32'(s.awaddr));
               bresp_q   <= irq_resp(32'(s.awaddr));
               bvalid_q  <= 1'b1;
               w_state_q <= W_RESP;
            end
            W_RESP: if (s.bready) begin
               bvalid_q  <= 1'b0;
               awready_q <= 1'b1;
               wready_q  <= 1'b1;
               w_state_q <= W_IDLE;
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (ar_hs) begin
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rdata_q   <= rd_data;
                  rresp_q   <= irq_resp(32'(s.araddr));
                  r_state_q <= R_VALID;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_VALID: if (s.rready) begin
               rvalid_q  <= 1'b0;
               arready_q <= 1'b1;
               r_state_q <= R_IDLE;
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/axilregs_irq_ctrl.sv
// rtl/axilregs_irq_ctrl.sv - NUM_SRC-source interrupt controller: sticky/level status, enable, W1C/W1S, global enable
module axilregs_irq_ctrl
   import axilregs_pkg::*;
#(
   parameter int          NUM_SRC     = 14,
   parameter logic [31:0] STICKY_MASK = 32'h0000_003F,
   parameter int          ADDR_W      = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   axilregs_irq_ctrl_if.slave s,
   input  logic [NUM_SRC-1:0] src_i,
   output logic               irq_o
);

   localparam logic [31:0] SRC_MASK = (NUM_SRC >= 32) ? 32'hFFFF_FFFF : ((32'h1 << NUM_SRC) - 32'h1);
   localparam logic [31:0] STICKY   = STICKY_MASK & SRC_MASK;
   localparam logic [31:0] LEVEL    = ~STICKY_MASK & SRC_MASK;

   logic              wr_en, rd_en;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [31:0]       wr_data, rd_data;
   logic [3:0]        wr_strb;

   logic        gie_q, gie_d, irq_q, irq_d;
   logic [31:0] ier_q, ier_d, isr_q, isr_d, src_q, src_d;
   logic [31:0] src_ext, wa, ra, bm, wbits, clr, set, rise;
   ctrl_irq_reg_t ctrl_rd;

   axil_slave_if #(.ADDR_W(ADDR_W)) u_slave (
      .clk     (clk),
      .rst_n   (rst_n),
      .s       (s),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign src_ext = 32'(src_i);

   always_comb begin
      wa     = 32'(wr_addr) & ~32'h3;
      bm     = strb_mask(wr_strb);
      wbits  = wr_data & bm;
      gie_d  = gie_q;
      ier_d  = ier_q;
      src_d  = src_ext;
      clr    = '0;
      set    = '0;
      if (wr_en) begin
         case (wa)
            IRQ_CTRL_OFF: if (wr_strb[0]) gie_d = wr_data[0];
            IRQ_IER_OFF:  ier_d = ((ier_q & ~bm) | wbits) & SRC_MASK;
            IRQ_ICR_OFF:  clr = wbits & STICKY;
            IRQ_ISET_OFF: set = wbits & STICKY;
            default: ;
         endcase
      end
      // Applying set after clear makes a same-cycle event survive a W1C.
      rise  = src_ext & ~src_q & STICKY;
      isr_d = (((isr_q & ~clr) | set | rise) & STICKY) | (src_ext & LEVEL);
      irq_d = gie_q & (|(isr_q & ier_q));
   end

   always_comb begin
      ctrl_rd     = '0;
      ctrl_rd.gie = gie_q;
      ra          = 32'(rd_addr) & ~32'h3;
      rd_data     = '0;
      if (rd_en) begin
         case (ra)
            IRQ_CTRL_OFF: rd_data = ctrl_rd;
            IRQ_IER_OFF:  rd_data = ier_q;
            IRQ_RAW_OFF:  rd_data = src_q;
            IRQ_ISR_OFF:  rd_data = isr_q;
            IRQ_MIS_OFF:  rd_data = isr_q & ier_q;
            default:      rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gie_q <= 1'b0;
         ier_q <= '0;
         isr_q <= '0;
         src_q <= '0;
         irq_q <= 1'b0;
      end else begin
         gie_q <= gie_d;
         ier_q <= ier_d;
         isr_q <= isr_d;
         src_q <= src_d;
         irq_q <= irq_d;
      end
   end

   assign irq_o = irq_q;

endmodule

// File: tb/tb_axilregs_irq_ctrl.sv
// tb/tb_axilregs_irq_ctrl.sv - directed self-checking bench for axilregs_irq_ctrl
module tb_axilregs_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [13:0] src_i = '0;
   logic        irq_o;
   int          checks = 0;
   int          errors = 0;

   axilregs_irq_ctrl_if #(.ADDR_W(5)) bus ();

   axilregs_irq_ctrl #(.NUM_SRC(14), .STICKY_MASK(32'h0000_003F), .ADDR_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (bus),
      .src_i (src_i),
      .irq_o (irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st,
                            input logic [1:0] exp_resp, input bit pulse0);
      bit aw_d = 0, w_d = 0, ahs, whs, got = 0;
      logic [1:0] resp = 2'bxx;
      int n = 0;
      bus.awaddr = a; bus.awvalid = 1'b1;
      bus.wdata = d; bus.wstrb = st; bus.wvalid = 1'b1;
      while (!(aw_d && w_d) && n < 20) begin
         @(negedge clk);
         ahs = bus.awvalid && bus.awready;
         whs = bus.wvalid && bus.wready;
         @(posedge clk); #1;
         if (ahs) begin aw_d = 1; bus.awvalid = 1'b0; end
         if (whs) begin w_d = 1; bus.wvalid = 1'b0; end
         n++;
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      if (pulse0) src_i[0] = 1'b1;
      bus.bready = 1'b1;
      n = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (bus.bvalid) begin got = 1; resp = bus.bresp; end
         @(posedge clk); #1;
         n++;
      end
      bus.bready = 1'b0;
      chk("wr_b_seen", 32'(got), 32'd1);
      chk("wr_bresp", 32'(resp), 32'(exp_resp));
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] data, output logic [1:0] resp);
      bit hs, done = 0, got = 0;
      int n = 0;
      data = 'x; resp = 'x;
      bus.araddr = a; bus.arvalid = 1'b1;
      while (!done && n < 20) begin
         @(negedge clk);
         hs = bus.arvalid && bus.arready;
         @(posedge clk); #1;
         if (hs) begin done = 1; bus.arvalid = 1'b0; end
         n++;
      end
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      n = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (bus.rvalid) begin got = 1; data = bus.rdata; resp = bus.rresp; end
         @(posedge clk); #1;
         n++;
      end
      bus.rready = 1'b0;
      chk("rd_r_seen", 32'(got), 32'd1);
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp,
                         input logic [1:0] exp_resp);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(a, d, r);
      chk(tag, d, exp);
      chk({tag, "_resp"}, 32'(r), 32'(exp_resp));
   endtask

   task automatic split_write(input logic [4:0] a, input logic [31:0] d, input bit w_first);
      if (w_first) begin bus.wdata = d; bus.wstrb = 4'hF; bus.wvalid = 1'b1; end
      else begin bus.awaddr = a; bus.awvalid = 1'b1; end
      @(posedge clk); #1;
      if (w_first) bus.wdata = '0; else bus.awaddr = 5'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("first_ready_low", 32'(w_first ? bus.wready : bus.awready), 32'd0);
         @(posedge clk); #1;
      end
      if (w_first) begin bus.wvalid = 1'b0; bus.awaddr = a; bus.awvalid = 1'b1; end
      else begin bus.awvalid = 1'b0; bus.wdata = d; bus.wstrb = 4'hF; bus.wvalid = 1'b1; end
      @(negedge clk);
      chk("second_ready", 32'(w_first ? bus.awready : bus.wready), 32'd1);
      @(posedge clk); #1;
      bus.awaddr = 5'h00; bus.wdata = '0; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("b_held", 32'(bus.bvalid), 32'd1);
         chk("b_resp_held", 32'(bus.bresp), 32'd0);
         chk("no_2nd_aw", 32'(bus.awready), 32'd0);
         chk("no_2nd_w", 32'(bus.wready), 32'd0);
         @(posedge clk); #1;
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
      @(posedge clk); #1;
      bus.bready = 1'b0;
      chk("b_dropped", 32'(bus.bvalid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", 32'(bus.awready), 0);
      chk("rst_wready", 32'(bus.wready), 0);
      chk("rst_arready", 32'(bus.arready), 0);
      chk("rst_bvalid", 32'(bus.bvalid), 0);
      chk("rst_rvalid", 32'(bus.rvalid), 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_irq", 32'(irq_o), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int a = 0; a <= 8'h18; a += 4) rd_chk("rst_reg", 5'(a), 32'h0, 2'b00);
      rd_chk("unmapped_rd", 5'h1C, 32'h0, 2'b10);

      axi_write(5'h04, 32'h1, 4'hF, 2'b00, 0);
      axi_write(5'h00, 32'h1, 4'hF, 2'b00, 0);
      src_i[0] = 1'b1;
      @(posedge clk); #1;
      src_i[0] = 1'b0;
      chk("irq_lat1", 32'(irq_o), 0);
      @(posedge clk); #1;
      chk("irq_lat2", 32'(irq_o), 1);
      rd_chk("isr_pulse", 5'h0C, 32'h1, 2'b00);
      rd_chk("mis_pulse", 5'h18, 32'h1, 2'b00);
      axi_write(5'h10, 32'h1, 4'hF, 2'b00, 0);
      chk("irq_icr_still", 32'(irq_o), 1);
      @(posedge clk); #1;
      chk("irq_icr_fall", 32'(irq_o), 0);
      rd_chk("isr_cleared", 5'h0C, 32'h0, 2'b00);

      src_i[6] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rd_chk("isr_level", 5'h0C, 32'h40, 2'b00);
      rd_chk("raw_level", 5'h08, 32'h40, 2'b00);
      axi_write(5'h10, 32'h40, 4'hF, 2'b00, 0);
      rd_chk("isr_level_icr", 5'h0C, 32'h40, 2'b00);
      src_i[6] = 1'b0;
      @(posedge clk); #1;
      rd_chk("isr_level_drop", 5'h0C, 32'h0, 2'b00);

      axi_write(5'h10, 32'h1, 4'hF, 2'b00, 1);
      rd_chk("set_wins", 5'h0C, 32'h1, 2'b00);
      src_i[0] = 1'b0;

      axi_write(5'h10, 32'h3F, 4'hF, 2'b00, 0);
      axi_write(5'h04, 32'h0, 4'hF, 2'b00, 0);
      rd_chk("isr_clr_all", 5'h0C, 32'h0, 2'b00);
      axi_write(5'h14, 32'h3F, 4'hF, 2'b00, 0);
      rd_chk("isr_iset", 5'h0C, 32'h3F, 2'b00);
      rd_chk("mis_masked", 5'h18, 32'h0, 2'b00);
      chk("irq_masked", 32'(irq_o), 0);
      axi_write(5'h10, 32'h3F, 4'h0, 2'b00, 0);
      rd_chk("icr_no_strb", 5'h0C, 32'h3F, 2'b00);
      axi_write(5'h04, 32'hFFFF_FF01, 4'b0001, 2'b00, 0);
      rd_chk("ier_strb", 5'h04, 32'h1, 2'b00);
      chk("irq_ier", 32'(irq_o), 1);
      rd_chk("mis_ier", 5'h18, 32'h1, 2'b00);

      split_write(5'h04, 32'h0000_0A5A, 0);
      rd_chk("ier_aw_first", 5'h04, 32'h0A5A, 2'b00);
      rd_chk("ctrl_kept", 5'h00, 32'h1, 2'b00);
      split_write(5'h04, 32'h0000_1234, 1);
      rd_chk("ier_w_first", 5'h04, 32'h1234, 2'b00);
      axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, 2'b00, 0);
      rd_chk("ier_width", 5'h04, 32'h3FFF, 2'b00);
      axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
      rd_chk("unmapped_rd2", 5'h1C, 32'h0, 2'b10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
